// File: rtl/uart_rx.sv
// Serial receiver: start bit, DATA_BITS data LSB first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to add the parity bit and drive parity_error.
module uart_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 incoming_data,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int unsigned   TW        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned   IW        = $clog2(DATA_BITS);
  localparam logic [TW-1:0] SAMPLE    = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 bad_parity_q, bad_parity_d;
`endif

  logic line, sample, bit_end;
  assign line    = sync2_q;
  assign sample  = (tick_q == SAMPLE);
  assign bit_end = (tick_q == LAST_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      tick_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      bad_parity_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= incoming_data;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      bad_parity_q <= bad_parity_d;
`endif
    end
  end

  // tick_q is aligned to the bit boundary as seen after the synchroniser: the IDLE cycle
  // that first sees the low line is tick 0 of the start bit, so CLKS_PER_BIT=1 needs no gap.
  always_comb begin
    state_d      = state_q;
    tick_d       = bit_end ? '0 : tick_q + TW'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = 1'b0;
    bad_parity_d = bad_parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (line) begin
          tick_d = '0;
        end else begin
          state_d = bit_end ? S_DATA : S_START;
          idx_d   = '0;
`ifdef UART_RX_PARITY_EN
          bad_parity_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (sample && line) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (sample) shift_d[idx_q] = line;
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) bad_parity_d = line ^ (^shift_q);
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (sample) begin
          tick_d = '0;
          if (!line) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (bad_parity_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end
`endif
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        tick_d = '0;
        if (line) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at 16 clk/bit, one at 1 clk/bit, shared clock and reset.
// Expected words and arrival cycles come from the frame format and the latency formula.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx   [2];
  logic [7:0] dat  [2];
  logic       vld  [2];
  logic       ferr [2];
  logic       perr [2];

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .reset(rst_n), .incoming_data(rx[0]), .data(dat[0]),
    .data_valid(vld[0]), .frame_error(ferr[0]), .parity_error(perr[0])
  );

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .incoming_data(rx[1]), .data(dat[1]),
    .data_valid(vld[1]), .frame_error(ferr[1]), .parity_error(perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks, nerrors;
  int fcnt[2], pcnt[2], badchg[2], longp[2];
  logic [7:0] prev_dat[2];
  logic       prev_vld[2];
  logic [63:0] obs0[$], obs1[$], exp0[$], exp1[$];

  // Observed words are stamped with the posedge count at which data_valid is seen high.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rst_n) begin
        if (vld[w]) begin
          if (w == 0) obs0.push_back({32'(cyc), 24'd0, dat[w]});
          else        obs1.push_back({32'(cyc), 24'd0, dat[w]});
        end
        if (ferr[w]) fcnt[w]++;
        if (perr[w]) pcnt[w]++;
        if (!vld[w] && dat[w] !== prev_dat[w]) badchg[w]++;
        if (vld[w] && prev_vld[w]) longp[w]++;
      end
      prev_dat[w] = dat[w];
      prev_vld[w] = vld[w];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb_of(input int w);
    return (w == 0) ? 16 : 1;
  endfunction

  function automatic int latency(input int cpb);
    int nbits;
    nbits = 9;
`ifdef UART_RX_PARITY_EN
    nbits = 10;
`endif
    return 2 + nbits * cpb + (cpb - 1) / 2 + 1;
  endfunction

  task automatic drive_bit(input int w, input logic v, input int n, output int t0);
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rx[w] = v;
        t0 = cyc;
      end
    end
  endtask

  task automatic send_frame(input int w, input logic [7:0] b, input logic par_flip,
                            input logic stop_v, input int stop_bits, output int t0);
    int d;
    drive_bit(w, 1'b0, cpb_of(w), t0);
    for (int k = 0; k < 8; k++) drive_bit(w, b[k], cpb_of(w), d);
`ifdef UART_RX_PARITY_EN
    drive_bit(w, (^b) ^ par_flip, cpb_of(w), d);
`else
    d = int'(par_flip);
`endif
    drive_bit(w, stop_v, cpb_of(w) * stop_bits, d);
  endtask

  task automatic expect_word(input int w, input logic [7:0] b, input int t0);
    if (w == 0) exp0.push_back({32'(t0 + latency(cpb_of(w))), 24'd0, b});
    else        exp1.push_back({32'(t0 + latency(cpb_of(w))), 24'd0, b});
  endtask

  task automatic good_frame(input int w, input logic [7:0] b);
    int t0;
    send_frame(w, b, 1'b0, 1'b1, 1, t0);
    expect_word(w, b, t0);
  endtask

  task automatic drain(input int w, input string tag);
    logic [63:0] o, e;
    if (w == 0) begin
      chk({tag, "_count"}, 64'(obs0.size()), 64'(exp0.size()));
      while (obs0.size() > 0 && exp0.size() > 0) begin
        o = obs0.pop_front();
        e = exp0.pop_front();
        chk({tag, "_word_at_cycle"}, o, e);
      end
      obs0.delete();
      exp0.delete();
    end else begin
      chk({tag, "_count"}, 64'(obs1.size()), 64'(exp1.size()));
      while (obs1.size() > 0 && exp1.size() > 0) begin
        o = obs1.pop_front();
        e = exp1.pop_front();
        chk({tag, "_word_at_cycle"}, o, e);
      end
      obs1.delete();
      exp1.delete();
    end
  endtask

  initial begin
    int d, t0, f0, gap;
    logic [7:0] b;

    rst_n = 1'b0;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("reset_data", 64'(dat[w]), 64'd0);
      chk("reset_flags", {61'd0, vld[w], ferr[w], perr[w]}, 64'd0);
    end
    rst_n = 1'b1;
    drive_bit(0, 1'b1, 8, d);
    chk("idle_after_reset", 64'(obs0.size() + obs1.size() + fcnt[0] + fcnt[1]), 64'd0);

    // Word 0xA5 at 16 clk/bit
    good_frame(0, 8'hA5);
    drive_bit(0, 1'b1, 20, d);
    drain(0, "a5");
    chk("a5_data_port", 64'(dat[0]), 64'hA5);
    chk("a5_no_frame_err", 64'(fcnt[0]), 64'd0);

    // Short low glitch must not start a frame
    drive_bit(0, 1'b0, 4, d);
    drive_bit(0, 1'b1, 40, d);
    drain(0, "glitch");
    chk("glitch_no_frame_err", 64'(fcnt[0]), 64'd0);

    // Stop bit held low for three bit times, then recovery
    f0 = fcnt[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0, 3, t0);
    drive_bit(0, 1'b1, 32, d);
    chk("break_frame_err_once", 64'(fcnt[0] - f0), 64'd1);
    chk("break_data_kept", 64'(dat[0]), 64'hA5);
    drain(0, "break_no_word");
    good_frame(0, 8'h81);
    drive_bit(0, 1'b1, 20, d);
    drain(0, "after_break");
    chk("after_break_data_port", 64'(dat[0]), 64'h81);

    // 1 clk/bit, back-to-back frames
    good_frame(1, 8'h55);
    good_frame(1, 8'h0F);
    drive_bit(1, 1'b1, 8, d);
    drain(1, "b2b_cpb1");

    // Random words: back-to-back at 1 clk/bit, random gaps (including none) at 16 clk/bit
    for (int i = 0; i < 8; i++) good_frame(1, 8'($urandom_range(0, 255)));
    drive_bit(1, 1'b1, 8, d);
    drain(1, "rand_cpb1");
    for (int i = 0; i < 4; i++) begin
      good_frame(0, 8'($urandom_range(0, 255)));
      gap = (i == 1) ? 0 : int'($urandom_range(1, 20));
      if (gap > 0) drive_bit(0, 1'b1, gap, d);
    end
    drive_bit(0, 1'b1, 20, d);
    drain(0, "rand_cpb16");

`ifdef UART_RX_PARITY_EN
    b = dat[0];
    send_frame(0, 8'h07, 1'b1, 1'b1, 1, t0);
    drive_bit(0, 1'b1, 20, d);
    chk("parity_err_once", 64'(pcnt[0]), 64'd1);
    chk("parity_err_data_kept", 64'(dat[0]), 64'(b));
    drain(0, "parity_bad_no_word");
    good_frame(0, 8'h07);
    drive_bit(0, 1'b1, 20, d);
    drain(0, "parity_good");
    chk("parity_good_data_port", 64'(dat[0]), 64'h07);
    chk("parity_good_no_err", 64'(pcnt[0]), 64'd1);
`else
    chk("parity_err_tied_low", 64'(pcnt[0] + pcnt[1]), 64'd0);
`endif

    // Reset mid-frame
    good_frame(0, 8'hC3);
    drive_bit(0, 1'b1, 20, d);
    drain(0, "pre_reset");
    f0 = fcnt[0];
    drive_bit(0, 1'b0, 16, d);
    drive_bit(0, 1'b1, 16, d);
    drive_bit(0, 1'b0, 8, d);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    #1;
    chk("midreset_data", 64'(dat[0]), 64'd0);
    chk("midreset_flags", {61'd0, vld[0], ferr[0], perr[0]}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(0, 1'b1, 200, d);
    drain(0, "midreset_discard");
    chk("midreset_no_frame_err", 64'(fcnt[0] - f0), 64'd0);
    good_frame(0, 8'h5A);
    drive_bit(0, 1'b1, 20, d);
    drain(0, "post_reset");

    chk("data_changed_without_valid", 64'(badchg[0] + badchg[1]), 64'd0);
    chk("valid_longer_than_one", 64'(longp[0] + longp[1]), 64'd0);
    chk("cpb1_no_frame_err", 64'(fcnt[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
